// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM states, default
// frame geometry and the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned DEFAULT_OSF   = 8;
  localparam int unsigned DEFAULT_NBITS = 8;
  localparam logic        LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_osf_sample_counter.sv
// Oversample counter: counts Tick strobes within one bit period and flags
// the mid-start point (Half) and the mid-bit sample point (Full).
module osf_sample_counter #(
  parameter int unsigned OSF = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Tick,
  output logic Half,
  output logic Full
);

  localparam int unsigned CW = $clog2(OSF);

  logic [CW-1:0] r_count;

  // Saturates at OSF-1; the FSM always clears on a state change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Tick) begin
      if (Clear) begin
        r_count <= '0;
      end else if (r_count != CW'(OSF - 1)) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign Half = (r_count == CW'(OSF / 2 - 1));
  assign Full = (r_count == CW'(OSF - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, stop check and
// valid/ready delivery. Optional even parity under `UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OSF   = DEFAULT_OSF,
  parameter int unsigned NBITS = DEFAULT_NBITS
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             Rx,
  output logic [NBITS-1:0] Data,
  output logic             Valid,
  input  logic             Ready,
  output logic             FrameErr,
  output logic             Overrun,
`ifdef UART_RX_PARITY_EN
  output logic             ParityErr,
`endif
  output logic             Busy
);

  localparam int unsigned BW = $clog2(NBITS + 1);

  rx_state_e        r_state, w_state_next;
  logic [NBITS-1:0] r_shift;
  logic [BW-1:0]    r_bit_idx;
  logic [NBITS-1:0] r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_half, w_full;
  logic             w_clear, w_sample, w_idx_clear, w_deliver, w_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad, r_parity_err, w_par_sample;
`endif

  osf_sample_counter #(.OSF(OSF)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (w_clear),
    .Tick  (Tick),
    .Half  (w_half),
    .Full  (w_full)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_sample     = 1'b0;
    w_idx_clear  = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    if (Tick) begin
      case (r_state)
        ST_IDLE: begin
          w_clear = 1'b1;
          if (Rx != LINE_IDLE) w_state_next = ST_START;
        end
        ST_START: begin
          if (w_half) begin
            w_clear = 1'b1;
            if (Rx == LINE_IDLE) begin
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_DATA;
              w_idx_clear  = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_full) begin
            w_clear  = 1'b1;
            w_sample = 1'b1;
            if (r_bit_idx == BW'(NBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = ST_PARITY;
`else
              w_state_next = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full) begin
            w_clear      = 1'b1;
            w_par_sample = 1'b1;
            w_state_next = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_full) begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
            if (Rx == LINE_IDLE) begin
`ifdef UART_RX_PARITY_EN
              w_deliver = !r_par_bad;
`else
              w_deliver = 1'b1;
`endif
            end else begin
              w_frame_err = 1'b1;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_idx_clear) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + BW'(1);
        r_shift   <= {Rx, r_shift[NBITS-1:1]};
      end
      // A delivery on the same cycle as a consume replaces the word in place.
      if (w_deliver) begin
        if (!r_valid || Ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_sample && ((^r_shift) ^ Rx);
      if (w_idx_clear)       r_par_bad <= 1'b0;
      else if (w_par_sample) r_par_bad <= (^r_shift) ^ Rx;
    end
  end

  assign ParityErr = r_parity_err;
`endif

  assign Data     = r_data;
  assign Valid    = r_valid;
  assign FrameErr = r_frame_err;
  assign Overrun  = r_overrun;
  assign Busy     = (r_state != ST_IDLE);

endmodule
